// File: rtl/ifft_pkg.sv
// ifft_pkg: shared constants, framing states and rescale helpers for the IFFT source deframer
package ifft_pkg;
  localparam int N_POINTS = 1024;
  localparam int CNT_W = 10;
  localparam int DATA_W = 8;
  localparam int OUT_W = 16;
  localparam int EXP_W = 6;
  localparam int FIFO_DEPTH = 16;
  localparam int READY_MARGIN = 4;
  localparam int SH_MAX = OUT_W - DATA_W;
  localparam int SH_W = $clog2(SH_MAX + 1);
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_INVALID = 2'b01;
  typedef enum logic [1:0] {IDLE, IN_FRAME, DROP} state_t;
  typedef logic [SH_W-1:0] sh_t;
  // a negative block exponent means the core scaled down; undo it, bounded so nothing saturates
  function automatic sh_t shift_amt(input logic signed [EXP_W-1:0] e);
    int n;
    n = -int'(e);
    return sh_t'(n < 0 ? 0 : n > SH_MAX ? SH_MAX : n);
  endfunction
  function automatic logic [OUT_W-1:0] rescale(input logic signed [DATA_W-1:0] d, input sh_t sh);
    return OUT_W'(d) << sh;
  endfunction
endpackage

// File: rtl/ifft_out_fifo.sv
// ifft_out_fifo: synchronous show-ahead FIFO with occupancy count; data reads as zero when empty
module ifft_out_fifo #(
  parameter int DEPTH = 16,
  parameter int W = 34
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [W-1:0]           din,
  input  logic                   rd_en,
  output logic [W-1:0]           dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic wr, rd;
  assign rd = rd_en & !empty;
  assign wr = wr_en & (!full | rd);
  assign empty = count == '0;
  assign full = count == (AW+1)'(DEPTH);
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (wr) mem[wp] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      wp <= wp + AW'(wr);
      rp <= rp + AW'(rd);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/ifft_source_deframer.sv
// ifft_source_deframer: checks IFFT core output framing, rescales samples by the block
// exponent and buffers them for a valid/ready downstream with per-frame status.
module ifft_source_deframer
  import ifft_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              source_valid,
  input  logic              source_sop,
  input  logic              source_eop,
  input  logic [DATA_W-1:0] source_real,
  input  logic [DATA_W-1:0] source_imag,
  input  logic [EXP_W-1:0]  source_exp,
  input  logic [1:0]        source_error,
  output logic              core_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_real,
  output logic [OUT_W-1:0]  out_imag,
  output logic              out_sop,
  output logic              out_eop,
  output logic [CNT_W-1:0]  fft_out_cnt,
  output logic              frame_done,
  output logic              frame_err,
  output logic              overflow
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int FW = 2 * OUT_W + 2;
  state_t state, nxt;
  logic v1, sop1, eop1, v2, sop2, eop2;
  logic [DATA_W-1:0] re1, im1;
  logic [EXP_W-1:0] exp1, exp_q;
  logic [1:0] err1;
  logic [OUT_W-1:0] re2, im2;
  logic [CNT_W-1:0] cnt;
  logic start, last, bad, push, done_n, pop, full, empty;
  logic [CW-1:0] count;
  logic [FW-1:0] dout;
  sh_t sh;
  always_ff @(posedge clk) begin
    v1 <= reset ? 1'b0 : source_valid;
    sop1 <= source_sop;
    eop1 <= source_eop;
    re1 <= source_real;
    im1 <= source_imag;
    exp1 <= source_exp;
    err1 <= source_error;
  end
  assign start = sop1 && err1 == ERR_NONE;
  assign last = cnt == CNT_W'(N_POINTS - 1);
  // a clean sop always opens a frame, even when it also flags the previous one as broken
  always_comb begin
    nxt = state;
    push = 1'b0;
    bad = 1'b0;
    done_n = 1'b0;
    if (v1)
      case (state)
        IDLE: begin
          nxt = start ? IN_FRAME : DROP;
          push = start;
          bad = !start;
        end
        IN_FRAME: begin
          bad = sop1 || err1 != ERR_NONE || eop1 != last;
          push = !bad || start;
          done_n = !bad && eop1;
          nxt = start ? IN_FRAME : bad ? DROP : eop1 ? IDLE : IN_FRAME;
        end
        DROP: begin
          nxt = start ? IN_FRAME : eop1 ? IDLE : DROP;
          push = start;
        end
        default: nxt = IDLE;
      endcase
  end
  assign sh = shift_amt(start ? exp1 : exp_q);
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      exp_q <= '0;
      v2 <= 1'b0;
      frame_done <= 1'b0;
      frame_err <= 1'b0;
      overflow <= 1'b0;
      core_ready <= 1'b0;
    end else begin
      state <= nxt;
      v2 <= push;
      frame_done <= done_n;
      frame_err <= frame_err | bad;
      overflow <= overflow | (v2 & full & !pop);
      core_ready <= count <= CW'(FIFO_DEPTH - READY_MARGIN - 1);
      if (push) cnt <= start ? CNT_W'(1) : cnt + CNT_W'(1);
      if (push && start) exp_q <= exp1;
    end
  always_ff @(posedge clk) begin
    sop2 <= sop1;
    eop2 <= done_n;
    re2 <= rescale(re1, sh);
    im2 <= rescale(im1, sh);
  end
  ifft_out_fifo #(.DEPTH(FIFO_DEPTH), .W(FW)) u_fifo (
    .clk(clk),
    .rst(reset),
    .wr_en(v2),
    .din({sop2, eop2, re2, im2}),
    .rd_en(pop),
    .dout(dout),
    .empty(empty),
    .full(full),
    .count(count)
  );
  assign out_valid = !empty;
  assign pop = out_valid & out_ready;
  assign {out_sop, out_eop, out_real, out_imag} = dout;
  assign fft_out_cnt = cnt;
endmodule
